aes_key_sched: RTL
==================

# aes_key_sched

Sequential AES-128 key scheduler that sits directly upstream of the AES round datapath. It accepts one 128-bit cipher key over a valid/ready handshake and streams round keys 0..10 as 128-bit words, one per accepted beat. It replaces the fully unrolled 1408-bit key expansion for iterative, one-round-per-cycle cipher engines. It uses four S-box instances and no 1408-bit expansion bus.

## Interface
- No parameters. AES-128 only; Nk=4, Nr=10 fixed.
- clk  input  1  sole clock, rising edge.
- rst_n  input  1  reset; one clock, asynchronous, active-low.
- key_valid  input  1  cipher key offered.
- key_ready  output  1  scheduler can accept a key.
- key  input  128  cipher key; key[127:96] is w0, FIPS-197 byte order (MSB = first byte).
- decrypt  input  1  sampled at key handshake; selects reverse emission order (see Configuration).
- rk_valid  output  1  round key presented.
- rk_ready  input  1  downstream consumes round key.
- rk  output  128  round key, same word/byte order as key.
- rk_idx  output  4  round number of rk, 0..10.
- rk_last  output  1  high with the final round key of the sequence.
- busy  output  1  high from key acceptance until the last rk handshake.

## Operation
- States: IDLE, EXPAND (macro builds only), EMIT.
- IDLE: key_ready=1. On key_valid&&key_ready: latch key as rk0, rcon=8'h01, idx=0, key_ready=0, busy=1. Next state is EMIT (forward) or EXPAND (reverse).
- EMIT (forward): rk_valid=1, rk=current key, rk_idx=idx. On rk_valid&&rk_ready:
  - If idx==10: go to IDLE. rk_valid=0, busy=0, key_ready=1.
  - Else: the current key is replaced by the next key, idx+1, and rcon advances.
- Next-key function: t = SubWord(RotWord(w3)) ^ {rcon,24'h0}; w0'=w0^t; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- RotWord is a left byte rotate. SubWord uses the standard AES S-box per byte.
- rcon sequence for rounds 1..10: 01,02,04,08,10,20,40,80,1b,36. Advance is xtime: shift left 1, then ^8'h1b if bit7 was set.
- rk_last = rk_valid && (final index for the current order).
- Backpressure: while rk_valid && !rk_ready, rk, rk_idx and rk_last hold stable. rk_valid never drops before its handshake.
- key_valid while busy: ignored. key_ready stays 0, and no new key is latched.
- key_ready and rk_valid are never high together.

## Timing
- Reset (async assert) drives: key_ready=0, rk_valid=0, rk=0, rk_idx=0, rk_last=0, busy=0. State goes to IDLE.
- key_ready rises on the first clk edge after rst_n deasserts.
- Reset mid-sequence aborts immediately. No partial key survives, and the sequence restarts only on a new key.
- Forward latency: key handshake at edge N gives rk0 valid from cycle N+1. With rk_ready held 1, rk1..rk10 follow on consecutive cycles.
- Last-to-next: the rk10 handshake at edge M puts key_ready=1 from cycle M+1. Minimum 12 cycles per key.
- All outputs are registered. Only the next-key logic is combinational from the working register to its own D input.

## Configuration
- AES_KEY_SCHED_DEC_EN defined:
  - Adds an 11x128 round-key store.
  - If decrypt=1 at handshake: EXPAND computes and stores rk0..rk10 over cycles N+1..N+10, with rk_valid=0.
  - EMIT then presents rk10 first, at cycle N+11, and steps down to rk0. rk_last is high on rk_idx=0.
  - If decrypt=0: forward behaviour exactly as without the macro.
- Undefined:
  - decrypt is ignored and order is always forward. rk_last is high on rk_idx=10.
  - No store is built and the EXPAND state does not exist.

## Test plan
- Key 2b7e151628aed2a6abf7158809cf4f3c, rk_ready=1, decrypt=0:
  - rk0 equals the key one cycle after the handshake.
  - rk1=a0fafe1788542cb123a339392a6c7605.
  - rk10=d014f9a8c9ee2589e13f0cc8b6630ca6 with rk_last=1.
  - key_ready=1 on the next cycle.
- Key 000102030405060708090a0b0c0d0e0f: rk10=13111d7fe3944a17f307a78b4d2b30c5. Covers the rcon wrap 80 to 1b to 36.
- Random rk_ready stalls, including 5 cycles on rk3:
  - rk, rk_idx and rk_valid stay stable across the stall.
  - The sequence matches the no-stall run, and no beat is duplicated or skipped.
- key_valid held high throughout a sequence: exactly one key is accepted per 11 rk handshakes. A second key offered while busy is not latched.
- rst_n pulsed low during rk5:
  - All outputs go to their reset values asynchronously.
  - A new key afterward yields a correct rk0..rk10.
- With AES_KEY_SCHED_DEC_EN and decrypt=1, key 2b7e...4f3c:
  - First rk_valid appears 11 cycles after the handshake, with rk_idx=10 and rk=d014f9a8c9ee2589e13f0cc8b6630ca6.
  - The last beat is rk0 equal to the key, with rk_last=1.

Source files
------------

// File: rtl/aes_key_sched.sv
// rtl/aes_key_sched.sv - sequential AES-128 round-key scheduler
//
// Purpose: accepts one 128-bit cipher key over a valid/ready handshake and
//    streams round keys 0..10 as 128-bit beats, one per accepted beat.
//    One next-key step per cycle, four S-box lookups, no 1408-bit bus.
//
// Configuration macro: AES_KEY_SCHED_DEC_EN
//    defined   : adds an 11x128 round-key store; decrypt=1 at key handshake
//                expands all keys first, then emits rk10 down to rk0.
//    undefined : decrypt is ignored, order is always rk0 up to rk10.
//
// Ports:
//    clk        in   1    rising-edge clock
//    rst_n      in   1    asynchronous active-low reset
//    key_valid  in   1    cipher key offered
//    key_ready  out  1    scheduler can accept a key
//    key        in   128  cipher key, key[127:96] = w0, MSB = first byte
//    decrypt    in   1    reverse emission order, sampled at key handshake
//    rk_valid   out  1    round key presented
//    rk_ready   in   1    downstream consumes round key
//    rk         out  128  round key, same order as key
//    rk_idx     out  4    round number of rk, 0..10
//    rk_last    out  1    final round key of the sequence
//    busy       out  1    key accepted, last rk handshake not yet done

module aes_key_sched (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         key_valid,
   output logic         key_ready,
   input  logic [127:0] key,
   input  logic         decrypt,
   output logic         rk_valid,
   input  logic         rk_ready,
   output logic [127:0] rk,
   output logic [3:0]   rk_idx,
   output logic         rk_last,
   output logic         busy
);

   // AES S-box, entry x lives at bits [8*(255-x) +: 8]
   localparam logic [2047:0] SBOX_TAB = {
      128'h637c777bf26b6fc53001672bfed7ab76,
      128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115,
      128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84,
      128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8,
      128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973,
      128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479,
      128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
      128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df,
      128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_EMIT   = 2'd1
`ifdef AES_KEY_SCHED_DEC_EN
      ,
      ST_EXPAND = 2'd2
`endif
   } state_t;

   function automatic logic [7:0] sbox(input logic [7:0] x);
      logic [10:0] base;
      base = {~x, 3'b000};
      return SBOX_TAB[base +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] r);
      return {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
   endfunction

   state_t        state_q, state_d;
   logic [127:0]  rk_q, rk_d;
   logic [3:0]    idx_q, idx_d;
   logic [7:0]    rcon_q, rcon_d;
   logic          rk_valid_q, rk_valid_d;
   logic          rk_last_q, rk_last_d;
   logic          key_ready_q, key_ready_d;
   logic          busy_q, busy_d;
   logic [127:0]  next_key;

`ifdef AES_KEY_SCHED_DEC_EN
   logic          dec_q, dec_d;
   logic [127:0]  store_q [11];
   logic [127:0]  store_d [11];
`else
   logic          unused_decrypt;
   assign unused_decrypt = decrypt;
`endif

   // One key-expansion step from the working register (rk_q).
   always_comb begin
      logic [31:0] t, n0, n1, n2, n3;
      t  = sub_word({rk_q[23:0], rk_q[31:24]}) ^ {rcon_q, 24'h000000};
      n0 = rk_q[127:96] ^ t;
      n1 = rk_q[95:64]  ^ n0;
      n2 = rk_q[63:32]  ^ n1;
      n3 = rk_q[31:0]   ^ n2;
      next_key = {n0, n1, n2, n3};
   end

   always_comb begin
      state_d     = state_q;
      rk_d        = rk_q;
      idx_d       = idx_q;
      rcon_d      = rcon_q;
      rk_valid_d  = rk_valid_q;
      rk_last_d   = rk_last_q;
      key_ready_d = key_ready_q;
      busy_d      = busy_q;
`ifdef AES_KEY_SCHED_DEC_EN
      dec_d       = dec_q;
      store_d     = store_q;
`endif
      case (state_q)
         ST_IDLE: begin
            key_ready_d = 1'b1;
            if (key_valid && key_ready_q) begin
               rk_d        = key;
               idx_d       = 4'd0;
               rcon_d      = 8'h01;
               key_ready_d = 1'b0;
               busy_d      = 1'b1;
               rk_last_d   = 1'b0;
`ifdef AES_KEY_SCHED_DEC_EN
               dec_d       = decrypt;
               store_d[0]  = key;
               if (decrypt) begin
                  state_d = ST_EXPAND;
               end else begin
                  state_d    = ST_EMIT;
                  rk_valid_d = 1'b1;
               end
`else
               state_d    = ST_EMIT;
               rk_valid_d = 1'b1;
`endif
            end
         end
         ST_EMIT: begin
            if (rk_ready) begin
               // rk_last_q marks the final index for whichever order is running
               if (rk_last_q) begin
                  state_d     = ST_IDLE;
                  rk_valid_d  = 1'b0;
                  rk_last_d   = 1'b0;
                  busy_d      = 1'b0;
                  key_ready_d = 1'b1;
               end else begin
`ifdef AES_KEY_SCHED_DEC_EN
                  if (dec_q) begin
                     idx_d     = idx_q - 4'd1;
                     rk_d      = store_q[idx_q - 4'd1];
                     rk_last_d = (idx_q == 4'd1);
                  end else begin
                     idx_d     = idx_q + 4'd1;
                     rk_d      = next_key;
                     rcon_d    = xtime(rcon_q);
                     rk_last_d = (idx_q == 4'd9);
                  end
`else
                  idx_d     = idx_q + 4'd1;
                  rk_d      = next_key;
                  rcon_d    = xtime(rcon_q);
                  rk_last_d = (idx_q == 4'd9);
`endif
               end
            end
         end
`ifdef AES_KEY_SCHED_DEC_EN
         ST_EXPAND: begin
            // rk_q finishes holding rk10, which is the first key emitted
            idx_d                 = idx_q + 4'd1;
            rk_d                  = next_key;
            rcon_d                = xtime(rcon_q);
            store_d[idx_q + 4'd1] = next_key;
            if (idx_q == 4'd9) begin
               state_d    = ST_EMIT;
               rk_valid_d = 1'b1;
            end
         end
`endif
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         rk_q        <= '0;
         idx_q       <= '0;
         rcon_q      <= '0;
         rk_valid_q  <= 1'b0;
         rk_last_q   <= 1'b0;
         key_ready_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef AES_KEY_SCHED_DEC_EN
         dec_q       <= 1'b0;
         for (int i = 0; i < 11; i++) begin
            store_q[i] <= '0;
         end
`endif
      end else begin
         state_q     <= state_d;
         rk_q        <= rk_d;
         idx_q       <= idx_d;
         rcon_q      <= rcon_d;
         rk_valid_q  <= rk_valid_d;
         rk_last_q   <= rk_last_d;
         key_ready_q <= key_ready_d;
         busy_q      <= busy_d;
`ifdef AES_KEY_SCHED_DEC_EN
         dec_q       <= dec_d;
         for (int i = 0; i < 11; i++) begin
            store_q[i] <= store_d[i];
         end
`endif
      end
   end

   assign key_ready = key_ready_q;
   assign rk_valid  = rk_valid_q;
   assign rk        = rk_q;
   assign rk_idx    = idx_q;
   assign rk_last   = rk_last_q;
   assign busy      = busy_q;

endmodule
